// File: rtl/uart_ctrl_regbank.sv
// uart_ctrl_regbank: per-channel UART CTRL/STATUS registers (send FSM, RX pop, sticky W1C errors, maskable irq) on one bus
module uart_ctrl_regbank #(
  parameter int WIDTH     = 32,
  parameter int N_CH      = 2,
  parameter int CNT_WIDTH = 9,
  parameter int ADDR_W    = $clog2(N_CH) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic                      i_wr,
  input  logic                      i_rd,
  input  logic [WIDTH-1:0]          i_reg_wr_data,
  output logic [WIDTH-1:0]          o_reg_rd_data,
  output logic                      o_rd_valid,
  input  logic [N_CH*CNT_WIDTH-1:0] i_fifo_tx_count,
  input  logic [N_CH*CNT_WIDTH-1:0] i_fifo_rx_count,
  input  logic [N_CH-1:0]           i_fifo_tx_full,
  input  logic [N_CH-1:0]           i_fifo_rx_not_empty,
  input  logic [N_CH-1:0]           i_rx_ovf,
  input  logic [N_CH-1:0]           i_tx_ovf,
  input  logic [N_CH-1:0]           i_frame_err,
  output logic [N_CH-1:0]           o_send_req,
  input  logic [N_CH-1:0]           i_send_ack,
  input  logic [N_CH-1:0]           i_send_done,
  output logic [N_CH-1:0]           o_rx_pop,
  output logic [N_CH-1:0]           o_irq
);
  typedef enum logic [1:0] {IDLE, PEND, BUSY} state_t;
  localparam int SB = 2 * CNT_WIDTH;
  state_t                 state_q [N_CH];
  state_t                 state_d [N_CH];
  logic [2:0]             ie_q [N_CH];
  logic [2:0]             ie_d [N_CH];
  logic [2:0]             sticky_q [N_CH];
  logic [2:0]             sticky_d [N_CH];
  logic [CNT_WIDTH-1:0]   rx_cnt_q [N_CH];
  logic [CNT_WIDTH-1:0]   rx_cnt_d [N_CH];
  logic [CNT_WIDTH-1:0]   tx_cnt_q [N_CH];
  logic [CNT_WIDTH-1:0]   tx_cnt_d [N_CH];
  logic [WIDTH-1:0]       ctrl_val [N_CH];
  logic [WIDTH-1:0]       stat_val [N_CH];
  logic [N_CH-1:0]        pop_q, pop_d, ftxf_q, ftxf_d, rxav_q, rxav_d, irq_q, irq_d;
  logic [N_CH-1:0]        ch_hit, wr_ctrl, wr_stat, busy, txe;
  logic [WIDTH-1:0]       rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   unused_wd;
  assign unused_wd = ^i_reg_wr_data;
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      ch_hit[c]  = (i_addr >> 1) == ADDR_W'(c);
      wr_ctrl[c] = i_wr && ch_hit[c] && !i_addr[0];
      wr_stat[c] = i_wr && ch_hit[c] && i_addr[0];
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= '{default: IDLE};
    else state_q <= state_d;
  end
  // ack wins over a same-cycle cancel write in PEND
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        IDLE: if (wr_ctrl[c] && i_reg_wr_data[0] && tx_cnt_q[c] != '0) state_d[c] = PEND;
        PEND: if (i_send_ack[c]) state_d[c] = i_send_done[c] ? IDLE : BUSY;
              else if (wr_ctrl[c] && !i_reg_wr_data[0]) state_d[c] = IDLE;
        BUSY: if (i_send_done[c]) state_d[c] = IDLE;
        default: state_d[c] = IDLE;
      endcase
    end
  end
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      o_send_req[c] = state_q[c] == PEND;
      busy[c]       = state_q[c] != IDLE;
    end
  end
  // set pulses are OR-ed after the W1C mask so a same-cycle set wins
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = i_rd;
    for (int c = 0; c < N_CH; c++) begin
      ie_d[c]     = wr_ctrl[c] ? i_reg_wr_data[4:2] : ie_q[c];
      pop_d[c]    = wr_ctrl[c] && i_reg_wr_data[1] && i_fifo_rx_not_empty[c];
      sticky_d[c] = (sticky_q[c] & ~(wr_stat[c] ? i_reg_wr_data[SB+3 +: 3] : 3'b0))
                  | {i_frame_err[c], i_tx_ovf[c], i_rx_ovf[c]};
      rx_cnt_d[c] = i_fifo_rx_count[c*CNT_WIDTH +: CNT_WIDTH];
      tx_cnt_d[c] = i_fifo_tx_count[c*CNT_WIDTH +: CNT_WIDTH];
      ftxf_d[c]   = i_fifo_tx_full[c];
      rxav_d[c]   = i_fifo_rx_not_empty[c];
      txe[c]      = tx_cnt_q[c] == '0;
      irq_d[c]    = (ie_q[c][0] & rxav_q[c]) | (ie_q[c][1] & txe[c]) | (ie_q[c][2] & |sticky_q[c]);
      ctrl_val[c] = WIDTH'({busy[c], ie_q[c], pop_q[c], busy[c]});
      stat_val[c] = WIDTH'({sticky_q[c], txe[c], rxav_q[c], ftxf_q[c], tx_cnt_q[c], rx_cnt_q[c]});
      if (i_rd && ch_hit[c]) rd_data_d = i_addr[0] ? stat_val[c] : ctrl_val[c];
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ie_q       <= '{default: '0};
      sticky_q   <= '{default: '0};
      rx_cnt_q   <= '{default: '0};
      tx_cnt_q   <= '{default: '0};
      pop_q      <= '0;
      ftxf_q     <= '0;
      rxav_q     <= '0;
      irq_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      ie_q       <= ie_d;
      sticky_q   <= sticky_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      pop_q      <= pop_d;
      ftxf_q     <= ftxf_d;
      rxav_q     <= rxav_d;
      irq_q      <= irq_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign o_reg_rd_data = rd_data_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_rx_pop      = pop_q;
  assign o_irq         = irq_q;
endmodule

// File: tb/tb_uart_ctrl_regbank.sv
// tb_uart_ctrl_regbank: scoreboard bench for uart_ctrl_regbank with 2 channels and a spare address bit
module tb_uart_ctrl_regbank;
  localparam int N_CH = 2;
  localparam int CW = 9;
  localparam int AW = 3;
  logic              i_clk = 0;
  logic              i_rst_n;
  logic [AW-1:0]     i_addr;
  logic              i_wr, i_rd;
  logic [31:0]       i_reg_wr_data;
  logic [31:0]       o_reg_rd_data;
  logic              o_rd_valid;
  logic [N_CH*CW-1:0] i_fifo_tx_count, i_fifo_rx_count;
  logic [N_CH-1:0]   i_fifo_tx_full, i_fifo_rx_not_empty, i_rx_ovf, i_tx_ovf, i_frame_err;
  logic [N_CH-1:0]   o_send_req, i_send_ack, i_send_done, o_rx_pop, o_irq;
  logic [31:0]       sb[$];
  int                n_chk = 0;
  int                n_fail = 0;
  uart_ctrl_regbank #(.WIDTH(32), .N_CH(N_CH), .CNT_WIDTH(CW), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_wr(i_wr), .i_rd(i_rd),
    .i_reg_wr_data(i_reg_wr_data), .o_reg_rd_data(o_reg_rd_data), .o_rd_valid(o_rd_valid),
    .i_fifo_tx_count(i_fifo_tx_count), .i_fifo_rx_count(i_fifo_rx_count),
    .i_fifo_tx_full(i_fifo_tx_full), .i_fifo_rx_not_empty(i_fifo_rx_not_empty),
    .i_rx_ovf(i_rx_ovf), .i_tx_ovf(i_tx_ovf), .i_frame_err(i_frame_err),
    .o_send_req(o_send_req), .i_send_ack(i_send_ack), .i_send_done(i_send_done),
    .o_rx_pop(o_rx_pop), .o_irq(o_irq)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge i_clk) begin
    if (o_rd_valid) begin
      if (sb.size() == 0) check("unexpected_rd", o_reg_rd_data, 32'hdead);
      else check("rd_data", o_reg_rd_data, sb.pop_front());
    end
  end
  function automatic logic [31:0] stat(input int rx, input int tx, input bit ftxf, input bit rxav,
                                       input bit rovf, input bit tovf, input bit ferr);
    return 32'(rx) | (32'(tx) << 9) | (32'(ftxf) << 18) | (32'(rxav) << 19) | (32'(tx == 0) << 20)
         | (32'(rovf) << 21) | (32'(tovf) << 22) | (32'(ferr) << 23);
  endfunction
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    i_wr = 1; i_addr = a; i_reg_wr_data = d;
    tick();
    i_wr = 0;
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    i_rd = 1; i_addr = a;
    tick();
    i_rd = 0;
  endtask
  initial begin
    i_rst_n = 0; i_addr = '0; i_wr = 0; i_rd = 0; i_reg_wr_data = '0;
    i_fifo_tx_count = '0; i_fifo_rx_count = '0; i_fifo_tx_full = '0; i_fifo_rx_not_empty = '0;
    i_rx_ovf = '0; i_tx_ovf = '0; i_frame_err = '0; i_send_ack = '0; i_send_done = '0;
    repeat (3) tick();
    check("rst_req", 32'(o_send_req), 0);
    check("rst_pop", 32'(o_rx_pop), 0);
    check("rst_irq", 32'(o_irq), 0);
    check("rst_rd_valid", 32'(o_rd_valid), 0);
    i_rst_n = 1;
    tick();
    rd(0, 32'h0);
    rd(1, stat(0, 0, 0, 0, 0, 0, 0));
    // send handshake on ch1
    i_fifo_tx_count = {9'd5, 9'd0};
    tick();
    wr(2, 32'h1);
    check("send_req_pend", 32'(o_send_req), 32'b10);
    rd(2, 32'h21);
    i_send_ack = 2'b10; tick(); i_send_ack = 0;
    check("send_req_busy", 32'(o_send_req), 0);
    rd(2, 32'h21);
    i_send_done = 2'b10; tick(); i_send_done = 0;
    rd(2, 32'h0);
    // send ignored at count 0, then cancel on ch0
    wr(0, 32'h1);
    check("send_ignored", 32'(o_send_req), 0);
    rd(0, 32'h0);
    i_fifo_tx_count = {9'd5, 9'd3};
    tick();
    wr(0, 32'h1);
    check("send_req_ch0", 32'(o_send_req), 32'b01);
    wr(0, 32'h0);
    check("send_cancel", 32'(o_send_req), 0);
    rd(0, 32'h0);
    // RX pop
    i_fifo_rx_not_empty = 2'b01;
    i_wr = 1; i_addr = 0; i_reg_wr_data = 32'h2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pop_b2b", 32'(o_rx_pop), 32'b01);
    end
    i_wr = 0;
    tick();
    check("pop_end", 32'(o_rx_pop), 0);
    i_fifo_rx_not_empty = 0;
    wr(0, 32'h2);
    check("pop_empty", 32'(o_rx_pop), 0);
    // sticky W1C
    i_rx_ovf = 2'b01; tick(); i_rx_ovf = 0;
    rd(1, stat(0, 3, 0, 0, 1, 0, 0));
    wr(1, 32'h200000);
    rd(1, stat(0, 3, 0, 0, 0, 0, 0));
    i_rx_ovf = 2'b01; tick();
    wr(1, 32'h200000);
    i_rx_ovf = 0;
    rd(1, stat(0, 3, 0, 0, 1, 0, 0));
    wr(1, 32'h200000);
    rd(1, stat(0, 3, 0, 0, 0, 0, 0));
    // irq on RX available
    wr(0, 32'h4);
    i_fifo_rx_not_empty = 2'b01; i_fifo_rx_count = {9'd0, 9'd4};
    tick();
    check("irq_lag", 32'(o_irq), 0);
    tick();
    check("irq_rxav", 32'(o_irq), 32'b01);
    rd(1, stat(4, 3, 0, 1, 0, 0, 0));
    i_fifo_rx_not_empty = 0; i_fifo_rx_count = '0;
    tick();
    check("irq_hold", 32'(o_irq), 32'b01);
    tick();
    check("irq_drain", 32'(o_irq), 0);
    i_frame_err = 2'b01; tick(); i_frame_err = 0;
    tick(); tick();
    check("irq_err_masked", 32'(o_irq), 0);
    // simultaneous read and write returns the old value
    sb.push_back(32'h4);
    i_rd = 1; i_wr = 1; i_addr = 0; i_reg_wr_data = 32'h10;
    tick();
    i_rd = 0; i_wr = 0;
    tick();
    check("irq_err", 32'(o_irq), 32'b01);
    rd(1, stat(0, 3, 0, 0, 0, 0, 1));
    wr(1, 32'h800000);
    tick();
    check("irq_err_clr", 32'(o_irq), 0);
    // reset mid-BUSY, invalid channel reads
    wr(2, 32'h1);
    i_send_ack = 2'b10; tick(); i_send_ack = 0;
    check("busy_pre_rst", 32'(o_send_req), 0);
    rd(2, 32'h21);
    wr(0, 32'h4);
    i_fifo_rx_not_empty = 2'b01;
    tick(); tick();
    check("irq_pre_rst", 32'(o_irq), 32'b01);
    rd(4, 32'h0);
    rd(5, 32'h0);
    i_rst_n = 0;
    tick();
    check("rst2_req", 32'(o_send_req), 0);
    check("rst2_irq", 32'(o_irq), 0);
    check("rst2_pop", 32'(o_rx_pop), 0);
    check("rst2_rd_valid", 32'(o_rd_valid), 0);
    check("rst2_rd_data", o_reg_rd_data, 0);
    i_rst_n = 1;
    tick();
    rd(2, 32'h0);
    rd(0, 32'h0);
    tick(); tick();
    check("irq_post_rst", 32'(o_irq), 0);
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
